// File: rtl/ring_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin ring arbiter.
package ring_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int N_DEF        = 8;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HOLD_W_DEF   = 8;
    localparam int ID_W_DEF     = 3;
    localparam int MAX_N        = 32;

    // Wrapping left rotate by one within the low n bits.
    function automatic logic [MAX_N-1:0] rotl1(
        input logic [MAX_N-1:0] v,
        input int               n
    );
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                r[(i + 1) % n] = v[i];
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] onehot2bin(input logic [MAX_N-1:0] v);
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                b = b | 5'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/ring_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above the
// pointer, wrapping, found with a double-width masked priority scan.
module rr_pick
    import ring_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] ptr_i,
    output logic [N-1:0] pick_o,
    output logic         any_o
);

    localparam int W2 = 2 * N;

    logic [N-1:0]  mask;
    logic [W2-1:0] dbl;
    logic [W2-1:0] first;

    // Lower copy keeps only bits at/above ptr; upper copy supplies the wrap.
    assign mask   = ~(ptr_i - N'(1));
    assign dbl    = {req_i, req_i & mask};
    assign first  = dbl & (~dbl + W2'(1));
    assign pick_o = first[N-1:0] | first[W2-1:N];
    assign any_o  = |req_i;

endmodule

// File: rtl/ring_arbiter.sv
// Round-robin ring arbiter with one-hot rotating priority pointer and
// bounded grant hold time.
module ring_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = HOLD_W_DEF,
    parameter int ID_W     = ID_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic [N-1:0]    ptr,
    output logic            timeout
);

    state_e            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic              gv_q, gv_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [N-1:0]      ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              to_q, to_d;

    logic [N-1:0] pick;
    logic         any_req;
    logic         owner_req;
    logic         at_limit;
    logic         ptr_ok;
    logic [N-1:0] ptr_rot;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any_req)
    );

    assign owner_req = req[id_q];
    assign at_limit  = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign ptr_ok    = (ptr_q != '0) && ((ptr_q & (ptr_q - N'(1))) == '0);
    assign ptr_rot   = N'(rotl1(MAX_N'(grant_q), N));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && any_req) begin
                    grant_d = pick;
                    id_d    = ID_W'(onehot2bin(MAX_N'(pick)));
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A dropped request wins over the hold limit: no timeout.
                if (!owner_req || at_limit) begin
                    grant_d = '0;
                    ptr_d   = ptr_rot;
                    state_d = IDLE;
                    to_d    = owner_req;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!ptr_ok) begin
            ptr_d = N'(1);
        end
        gv_d = |grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gv_q    <= 1'b0;
            id_q    <= '0;
            ptr_q   <= N'(1);
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign grant_id    = id_q;
    assign ptr         = ptr_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Scoreboard bench for ring_arbiter (N=8, MAX_HOLD=4): directed stimulus
// pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_ring_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic [7:0] ptr;
    logic       timeout;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  g;
        logic [2:0]  id;
        logic [7:0]  p;
        logic        to;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int unsigned cyc;
    int          tests;
    int          fails;

    ring_arbiter #(
        .N        (8),
        .MAX_HOLD (4),
        .HOLD_W   (8),
        .ID_W     (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .ptr         (ptr),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL stale: expectation for cycle %0d seen at %0d",
                         e.cyc, cyc);
            end else if (grant !== e.g || grant_valid !== (e.g != 8'h00) ||
                         grant_id !== e.id || ptr !== e.p ||
                         timeout !== e.to) begin
                fails++;
                $display("FAIL cyc%0d: got g=%h v=%b id=%0d p=%h to=%b, want g=%h v=%b id=%0d p=%h to=%b",
                         cyc, grant, grant_valid, grant_id, ptr, timeout,
                         e.g, (e.g != 8'h00), e.id, e.p, e.to);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs after the coming edge.
    task automatic expn(input logic [7:0] g, input logic [2:0] id,
                        input logic [7:0] p, input logic to);
        q.push_back('{cyc + 1, g, id, p, to});
    endtask

    // Expected outputs in the current cycle (no edge in between).
    task automatic expc(input logic [7:0] g, input logic [2:0] id,
                        input logic [7:0] p, input logic to);
        q.push_back('{cyc, g, id, p, to});
    endtask

    initial begin
        logic [7:0] g;
        logic [2:0] id;
        int         wait_cnt;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 8'hFF;

        // Reset with all requests pending.
        tick();
        expn(8'h00, 3'd0, 8'h01, 1'b0);
        tick();
        rst_n = 1'b1;
        expn(8'h01, 3'd0, 8'h01, 1'b0);
        tick();
        req = 8'h00;
        expn(8'h00, 3'd0, 8'h02, 1'b0);
        tick();

        // Single requester, released before the hold limit.
        req = 8'h08;
        expn(8'h08, 3'd3, 8'h02, 1'b0);
        tick();
        repeat (2) begin
            expn(8'h08, 3'd3, 8'h02, 1'b0);
            tick();
        end
        req = 8'h00;
        expn(8'h00, 3'd3, 8'h10, 1'b0);
        tick();

        // Full rotation with revokes, ptr wrapping 0x80 -> 0x01.
        req = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            id = 3'((4 + k) % 8);
            g  = 8'h01 << id;
            expn(g, id, g, 1'b0);
            tick();
            repeat (3) begin
                expn(g, id, g, 1'b0);
                tick();
            end
            expn(8'h00, id, 8'h01 << ((id + 1) % 8), 1'b1);
            tick();
        end

        // Wrap scan from ptr=0x10.
        req = 8'h09;
        expn(8'h01, 3'd0, 8'h10, 1'b0);
        tick();
        req = 8'h08;
        expn(8'h00, 3'd0, 8'h02, 1'b0);
        tick();
        expn(8'h08, 3'd3, 8'h02, 1'b0);
        tick();
        req = 8'h00;
        expn(8'h00, 3'd3, 8'h10, 1'b0);
        tick();

        // Enable gating in IDLE, ignored in BUSY.
        en  = 1'b0;
        req = 8'h04;
        repeat (2) begin
            expn(8'h00, 3'd3, 8'h10, 1'b0);
            tick();
        end
        en = 1'b1;
        expn(8'h04, 3'd2, 8'h10, 1'b0);
        tick();
        en = 1'b0;
        repeat (2) begin
            expn(8'h04, 3'd2, 8'h10, 1'b0);
            tick();
        end
        req = 8'h00;
        expn(8'h00, 3'd2, 8'h08, 1'b0);
        tick();
        en = 1'b1;

        // Request drop coinciding with the hold limit: release, no timeout.
        req = 8'h04;
        expn(8'h04, 3'd2, 8'h08, 1'b0);
        tick();
        req = 8'hF4;
        repeat (3) begin
            expn(8'h04, 3'd2, 8'h08, 1'b0);
            tick();
        end
        req = 8'h00;
        expn(8'h00, 3'd2, 8'h08, 1'b0);
        tick();

        // Asynchronous reset mid-grant (grant=0x20, hold_cnt=2).
        req = 8'h20;
        expn(8'h20, 3'd5, 8'h08, 1'b0);
        tick();
        expn(8'h20, 3'd5, 8'h08, 1'b0);
        tick();
        tick();
        expc(8'h00, 3'd0, 8'h01, 1'b0);
        rst_n = 1'b0;
        expn(8'h00, 3'd0, 8'h01, 1'b0);
        tick();
        rst_n = 1'b1;
        req   = 8'h24;
        expn(8'h04, 3'd2, 8'h01, 1'b0);
        tick();
        req = 8'h00;
        expn(8'h00, 3'd2, 8'h08, 1'b0);
        tick();

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
